// File: rtl/afifo_wburst_gen.sv
// Write-side burst traffic engine for the async FIFO: turns burst commands into
// winc/wdata writes, honours wfull and abort, and reports completion statistics.
module afifo_wburst_gen #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [DATA_WIDTH-1:0] cmd_base,
   input  logic                  cmd_mode,
   input  logic                  abort,
   input  logic                  wfull,
   output logic                  winc,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [LEN_WIDTH-1:0]  wr_count,
   output logic [15:0]           stall_cycles
);

   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

   state_t                state;
   logic [LEN_WIDTH-1:0]  rem;
   logic                  mode;
   logic [DATA_WIDTH-1:0] next_data;

   // Next word: increment, or shift with feedback from the two top bits
   always_comb begin
      next_data = wdata + DATA_WIDTH'(1);
      if (mode) begin
         next_data = {wdata[DATA_WIDTH-2:0], wdata[DATA_WIDTH-1] ^ wdata[DATA_WIDTH-2]};
      end
   end

   // Write strobe is combinational so a full FIFO blocks the write in the same cycle
   assign winc = (state == BURST) && !wfull && !abort;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state        <= IDLE;
         rem          <= '0;
         mode         <= 1'b0;
         wdata        <= '0;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         wr_count     <= '0;
         stall_cycles <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  rem          <= cmd_len;
                  wdata        <= cmd_base;
                  mode         <= cmd_mode;
                  wr_count     <= '0;
                  stall_cycles <= '0;
                  aborted      <= 1'b0;
                  cmd_ready    <= 1'b0;
                  busy         <= 1'b1;
                  if (cmd_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= BURST;
                  end
               end
            end
            BURST: begin
               // Abort takes priority over both stall and a pending final write
               if (abort) begin
                  aborted <= 1'b1;
                  state   <= DONE;
                  done    <= 1'b1;
               end else if (wfull) begin
                  if (stall_cycles != 16'hFFFF) begin
                     stall_cycles <= stall_cycles + 16'd1;
                  end
               end else begin
                  rem      <= rem - LEN_WIDTH'(1);
                  wr_count <= wr_count + LEN_WIDTH'(1);
                  wdata    <= next_data;
                  if (rem == LEN_WIDTH'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_afifo_wburst_gen.sv
// Directed bench for afifo_wburst_gen: a cycle model drives timing checks and
// pushes expected words to a scoreboard that a negedge monitor drains.
module tb_afifo_wburst_gen;

   logic        wclk;
   logic        wrst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_len;
   logic [31:0] cmd_base;
   logic        cmd_mode;
   logic        abort;
   logic        wfull;
   logic        winc;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [7:0]  wr_count;
   logic [15:0] stall_cycles;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_wdata = '0;

   afifo_wburst_gen #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_len(cmd_len), .cmd_base(cmd_base), .cmd_mode(cmd_mode), .abort(abort),
      .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy), .done(done),
      .aborted(aborted), .wr_count(wr_count), .stall_cycles(stall_cycles)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, expv);
      end
   endtask

   function automatic logic [31:0] adv(input logic [31:0] w, input logic m);
      if (m) return {w[30:0], w[31] ^ w[30]};
      return w + 32'd1;
   endfunction

   // Scoreboard: every accepted write must match the oldest expected word
   always @(negedge wclk) begin
      if (wrst_n === 1'b1 && winc === 1'b1) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_write: observed wdata %h expected no write", wdata);
         end
         if (exp_q.size() != 0) begin
            logic [31:0] ew;
            ew = exp_q.pop_front();
            n_checks++;
            assert (wdata === ew) else begin
               n_fail++;
               $error("FAIL wdata: observed %h expected %h", wdata, ew);
            end
         end
         last_wdata = wdata;
      end
   end

   task automatic check_reset_values(input string tag);
      chk({tag, "_winc"}, 32'(winc), 32'd0);
      chk({tag, "_wdata"}, wdata, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_aborted"}, 32'(aborted), 32'd0);
      chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
      chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   // One burst: stall_mask bit c raises wfull in BURST cycle c; abort_at aborts once
   // that many writes are accepted; rst_at pulses wrst_n in BURST cycle rst_at.
   task automatic run(input string tag, input int len, input logic [31:0] base,
                      input logic mode, input logic [31:0] stall_mask,
                      input int abort_at, input int rst_at);
      logic [31:0] mw;
      int          mrem, mcount, mstall, c;
      logic        mab, fin, ewinc;
      @(posedge wclk); #1;
      chk({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_len = 8'(len); cmd_base = base; cmd_mode = mode;
      @(posedge wclk); #1;
      mw = base; mrem = len; mcount = 0; mstall = 0; mab = 1'b0; c = 0;
      fin = (len == 0);
      while (!fin && c < 64) begin
         if (c == rst_at) begin
            wrst_n = 1'b0;
            cmd_valid = 1'b1;
            #1;
            check_reset_values({tag, "_rst"});
            chk({tag, "_rst_q_empty"}, 32'(exp_q.size()), 32'd0);
            @(posedge wclk); #1;
            @(negedge wclk);
            chk({tag, "_rst_hold_done"}, 32'(done), 32'd0);
            chk({tag, "_rst_hold_busy"}, 32'(busy), 32'd0);
            @(posedge wclk); #1;
            cmd_valid = 1'b0; wrst_n = 1'b1;
            @(negedge wclk);
            chk({tag, "_post_rst_done"}, 32'(done), 32'd0);
            chk({tag, "_post_rst_busy"}, 32'(busy), 32'd0);
            chk({tag, "_post_rst_ready"}, 32'(cmd_ready), 32'd1);
            return;
         end
         // Commands during the burst must be ignored
         cmd_valid = 1'b1; cmd_base = ~base;
         wfull = (c < 32) ? stall_mask[c] : 1'b0;
         abort = (abort_at >= 0 && mcount == abort_at);
         ewinc = !wfull && !abort;
         if (ewinc) exp_q.push_back(mw);
         @(negedge wclk);
         chk({tag, "_winc"}, 32'(winc), 32'(ewinc));
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         chk({tag, "_done_early"}, 32'(done), 32'd0);
         chk({tag, "_ready_burst"}, 32'(cmd_ready), 32'd0);
         if (wfull && !abort) chk({tag, "_hold_wdata"}, wdata, mw);
         if (abort) begin
            mab = 1'b1; fin = 1'b1;
         end else if (wfull) begin
            mstall++;
         end else begin
            mcount++; mrem--; mw = adv(mw, mode);
            if (mrem == 0) fin = 1'b1;
         end
         @(posedge wclk); #1;
         wfull = 1'b0; abort = 1'b0; c++;
      end
      cmd_valid = 1'b0;
      chk({tag, "_bounded"}, 32'(c < 64), 32'd1);
      @(negedge wclk);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_done_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_winc"}, 32'(winc), 32'd0);
      chk({tag, "_done_ready"}, 32'(cmd_ready), 32'd0);
      @(posedge wclk); #1;
      @(negedge wclk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_wr_count"}, 32'(wr_count), 32'(mcount));
      chk({tag, "_stall"}, 32'(stall_cycles), 32'(mstall));
      chk({tag, "_aborted"}, 32'(aborted), 32'(mab));
      chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      wrst_n = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_base = '0;
      cmd_mode = 1'b0; abort = 1'b0; wfull = 1'b0;
      #1 wrst_n = 1'b0;
      #1 check_reset_values("reset");
      repeat (3) @(posedge wclk);
      #1 wrst_n = 1'b1;

      run("basic", 4, 32'h10, 1'b0, 32'h0, -1, -1);
      chk("basic_last", last_wdata, 32'h13);
      chk("basic_wr_count_const", 32'(wr_count), 32'd4);
      run("stall", 4, 32'h10, 1'b0, 32'h6, -1, -1);
      chk("stall_count_const", 32'(stall_cycles), 32'd2);
      run("shift", 3, 32'hC000_0000, 1'b1, 32'h0, -1, -1);
      chk("shift_last", last_wdata, 32'h0000_0001);
      run("wrap", 3, 32'hFFFF_FFFE, 1'b0, 32'h0, -1, -1);
      chk("wrap_last", last_wdata, 32'h0000_0000);
      run("abort", 8, 32'h100, 1'b0, 32'h0, 3, -1);
      chk("abort_flag_const", 32'(aborted), 32'd1);
      run("abort_last", 2, 32'h200, 1'b0, 32'h0, 1, -1);
      run("abort_stall", 6, 32'h300, 1'b1, 32'h18, 4, -1);
      run("reset_mid", 8, 32'h400, 1'b0, 32'h0, -1, 2);
      run("after_rst", 1, 32'h55, 1'b0, 32'h0, -1, -1);
      chk("after_rst_last", last_wdata, 32'h55);
      run("zero_len", 0, 32'h77, 1'b0, 32'h0, -1, -1);
      chk("zero_len_count", 32'(wr_count), 32'd0);
      run("shift_zero", 3, 32'h0, 1'b1, 32'h1, -1, -1);
      chk("shift_zero_last", last_wdata, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/afifo_wburst_gen.md
# afifo_wburst_gen

Synthesizable write-side traffic engine for the async FIFO UVC. It accepts burst commands (length, base word, data mode) and drives the FIFO write port (winc/wdata) in the write clock domain, honouring wfull. It also reports completion, abort and stall statistics. It is the write-end counterpart of the read-side driver BFM and can be instantiated inside the write agent's BFM interface or used standalone in emulation.

## Interface
- DATA_WIDTH, 32, width of wdata and cmd_base; must be >= 2
- LEN_WIDTH, 8, width of cmd_len and wr_count
- wclk  input  1  write-domain clock
- wrst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  burst command valid
- cmd_ready  output  1  engine can accept a command
- cmd_len  input  LEN_WIDTH  number of words to write (0 allowed)
- cmd_base  input  DATA_WIDTH  first data word of the burst
- cmd_mode  input  1  0 = increment by 1, 1 = shift-feedback pattern
- abort  input  1  synchronous request to end the current burst
- wfull  input  1  FIFO full flag (write domain)
- winc  output  1  write strobe to the FIFO
- wdata  output  DATA_WIDTH  write data to the FIFO
- busy  output  1  burst in progress
- done  output  1  one-cycle completion pulse
- aborted  output  1  last burst ended by abort; held until next command accept
- wr_count  output  LEN_WIDTH  writes accepted in the current/last burst
- stall_cycles  output  16  BURST cycles with wfull=1, saturating at 0xFFFF

## Operation
- States: IDLE, BURST, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready the engine captures the command:
  - rem<=cmd_len, wdata<=cmd_base, mode<=cmd_mode
  - wr_count<=0, stall_cycles<=0, aborted<=0
  - next state is BURST, or DONE if cmd_len==0 (no writes issued)
- BURST:
  - winc = !wfull && !abort, combinational.
  - A write is accepted at every posedge where winc=1. On acceptance: rem-1, wr_count+1, wdata advances.
  - After the write with rem==1, next state is DONE.
  - abort=1 means winc=0 that cycle, aborted<=1, next state DONE. The remaining words are dropped.
  - When wfull=1 and abort=0, the engine stalls. stall_cycles+1 (saturating); wdata and rem hold.
  - If abort and the final write coincide, abort wins: no write, aborted=1.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in BURST and DONE. cmd_ready=1 only in IDLE. cmd_valid in other states is ignored; no queueing.
- Data advance rules:
  - mode 0: wdata+1, modulo 2^DATA_WIDTH (wraps 0xFFFF_FFFF to 0x0000_0000).
  - mode 1: {wdata[DW-2:0], wdata[DW-1]^wdata[DW-2]}. A zero base stays zero.
- wr_count and stall_cycles hold after DONE until the next accept.

## Timing
- Reset values (asserted asynchronously, released synchronously by the environment):
  - state IDLE, winc 0, wdata 0, busy 0, done 0, aborted 0, wr_count 0, stall_cycles 0.
  - cmd_ready is 1 whenever in IDLE. Commands presented while wrst_n=0 are ignored.
- Reset mid-burst: immediate return to reset values. The burst is lost and no done pulse is produced.
- Command accepted at edge N: state is BURST in cycle N+1, and winc can be high in cycle N+1.
- Burst of length L with no stalls:
  - winc is high for L consecutive cycles, N+1..N+L.
  - done is high in cycle N+L+1.
  - cmd_ready is high in cycle N+L+2.
- cmd_len=0: done is high in cycle N+1 with no winc.
- Throughput is 1 word/cycle. Each wfull=1 cycle adds exactly one cycle of latency.
- wdata is registered; winc is a combinational function of state, wfull and abort (no wclk-to-winc flop).

## Test plan
- Reset, then cmd_len=4, base=0x10, mode 0, wfull=0: winc high 4 cycles with wdata 0x10,0x11,0x12,0x13; done one cycle later; wr_count=4, stall_cycles=0, aborted=0.
- Same command with wfull=1 on the 2nd and 3rd BURST cycles: wdata 0x11 held across the stall; 4 writes total; stall_cycles=2; done 2 cycles later than in the first case.
- mode 1, base=0xC000_0000, len=3: written words are 0xC000_0000, 0x8000_0000, 0x0000_0001.
- mode 0, base=0xFFFF_FFFE, len=3: written words are 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- len=8, abort asserted after 3 accepted writes: winc low that same cycle; wr_count=3, aborted=1, done pulse next cycle; cmd_ready returns.
- wrst_n pulsed low during a len=8 burst after 2 writes: all outputs return to reset values immediately and no done pulse occurs. A new len=1 command afterwards completes normally.
- cmd_len=0: no winc, done in cycle N+1, wr_count=0.
